// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared widths, mult/div latencies, MD timer state encoding and PC-select codes
// for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned T_W     = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned PCSEL_W = 2;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    // The counter runs load..0 inclusive, so it loads one less than the busy length
    localparam logic [CNT_W-1:0] MD_MULT_LOAD = CNT_W'(MD_MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MD_DIV_LOAD  = CNT_W'(MD_DIV_CYCLES - 1);

    localparam logic [PCSEL_W-1:0] PC_SEL_SEQ     = 2'd0;
    localparam logic [PCSEL_W-1:0] PC_SEL_HANDLER = 2'd1;
    localparam logic [PCSEL_W-1:0] PC_SEL_EPC     = 2'd2;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // One ID source operand hazards against a later-stage producer not yet ready
    function automatic logic src_hazard(
        input logic [REG_W-1:0] rs,
        input logic [T_W-1:0]   tuse,
        input logic [REG_W-1:0] e_wa,
        input logic [T_W-1:0]   e_tnew,
        input logic [REG_W-1:0] m_wa,
        input logic [T_W-1:0]   m_tnew
    );
        return (rs != '0) &&
               (((rs == e_wa) && (tuse < e_tnew)) ||
                ((rs == m_wa) && (tuse < m_tnew)));
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div occupancy timer: IDLE/BUSY FSM with a down-counter giving 5 busy
// cycles for mult and 10 for div.
module md_busy_timer
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start seen while BUSY is ignored; the unit only accepts work when idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = div ? MD_DIV_LOAD : MD_MULT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data/mult-div stalls, exception/eret redirection.
// Optional PIPE_CTRL_STALL_CNT_EN adds a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [REG_W-1:0]   d_rs,
    input  logic [REG_W-1:0]   d_rt,
    input  logic [T_W-1:0]     d_tuse_rs,
    input  logic [T_W-1:0]     d_tuse_rt,
    input  logic [REG_W-1:0]   e_wa,
    input  logic [REG_W-1:0]   m_wa,
    input  logic [T_W-1:0]     e_tnew,
    input  logic [T_W-1:0]     m_tnew,
    input  logic               d_is_md,
    input  logic               e_md_start,
    input  logic               e_md_div,
    input  logic               exc_req,
    input  logic               eret_req,
    output logic               pc_en,
    output logic               fd_en,
    output logic               de_bubble,
    output logic               fd_flush,
    output logic               de_flush,
    output logic               em_flush,
    output logic               md_start_ok,
    output logic               md_busy,
    output logic               stall,
    output logic [PCSEL_W-1:0] pc_sel
`ifdef PIPE_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    logic data_stall;
    logic md_stall;

    assign data_stall = src_hazard(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew) |
                        src_hazard(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
    assign md_stall    = d_is_md & (md_busy | e_md_start);
    assign stall       = data_stall | md_stall;
    assign md_start_ok = e_md_start & ~exc_req;

    md_busy_timer u_md_busy_timer (
        .clk   (clk),
        .reset (reset),
        .start (md_start_ok),
        .div   (e_md_div),
        .busy  (md_busy)
    );

    // Redirection outranks stalling: the flushed ID instruction need not wait
    always_comb begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        de_bubble = 1'b0;
        fd_flush  = 1'b0;
        de_flush  = 1'b0;
        em_flush  = 1'b0;
        pc_sel    = PC_SEL_SEQ;
        if (exc_req) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
            pc_sel   = PC_SEL_HANDLER;
        end else if (eret_req) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
            pc_sel   = PC_SEL_EPC;
        end else if (stall) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
        end
    end

`ifdef PIPE_CTRL_STALL_CNT_EN
    // Only cycles that actually hold the front end are counted
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && !exc_req && !eret_req && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a cycle-level
// behavioural model (remaining-busy-cycles counter and plain hazard rules).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_wa, m_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_is_md, e_md_start, e_md_div, exc_req, eret_req;
    logic       pc_en, fd_en, de_bubble, fd_flush, de_flush, em_flush;
    logic       md_start_ok, md_busy, stall;
    logic [1:0] pc_sel;
`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state: busy cycles still owed by the mult/div unit, stall total
    int          busy_left = 0;
    logic [31:0] m_stall_cnt = '0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .e_wa        (e_wa),
        .m_wa        (m_wa),
        .e_tnew      (e_tnew),
        .m_tnew      (m_tnew),
        .d_is_md     (d_is_md),
        .e_md_start  (e_md_start),
        .e_md_div    (e_md_div),
        .exc_req     (exc_req),
        .eret_req    (eret_req),
        .pc_en       (pc_en),
        .fd_en       (fd_en),
        .de_bubble   (de_bubble),
        .fd_flush    (fd_flush),
        .de_flush    (de_flush),
        .em_flush    (em_flush),
        .md_start_ok (md_start_ok),
        .md_busy     (md_busy),
        .stall       (stall),
        .pc_sel      (pc_sel)
`ifdef PIPE_CTRL_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit dep(input logic [4:0] r, input logic [1:0] tuse);
        if (r == 0) return 1'b0;
        if (r == e_wa && int'(tuse) < int'(e_tnew)) return 1'b1;
        if (r == m_wa && int'(tuse) < int'(m_tnew)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        reset = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3;
        e_wa = 0; m_wa = 0; e_tnew = 0; m_tnew = 0;
        d_is_md = 0; e_md_start = 0; e_md_div = 0; exc_req = 0; eret_req = 0;
    endtask

    // Check every output against the model for the inputs already driven, then clock
    task automatic cycle();
        bit st, redirect;
        int e_pc_sel;
        #1;
        st = dep(d_rs, d_tuse_rs) || dep(d_rt, d_tuse_rt) ||
             (d_is_md && (busy_left > 0 || e_md_start));
        redirect = exc_req || eret_req;
        e_pc_sel = exc_req ? 1 : (eret_req ? 2 : 0);
        check("stall", 32'(stall), 32'(st));
        check("md_busy", 32'(md_busy), 32'(busy_left > 0));
        check("md_start_ok", 32'(md_start_ok), 32'(e_md_start && !exc_req));
        check("pc_sel", 32'(pc_sel), 32'(e_pc_sel));
        check("pc_en", 32'(pc_en), 32'(redirect || !st));
        check("fd_en", 32'(fd_en), 32'(redirect || !st));
        check("de_bubble", 32'(de_bubble), 32'(!redirect && st));
        check("flushes", 32'({fd_flush, de_flush, em_flush}), redirect ? 32'd7 : 32'd0);
`ifdef PIPE_CTRL_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_stall_cnt);
`endif
        @(posedge clk);
        if (reset) begin
            busy_left   = 0;
            m_stall_cnt = '0;
        end else begin
            if (st && !redirect && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (busy_left > 0) busy_left--;
            else if (e_md_start && !exc_req) busy_left = e_md_div ? 10 : 5;
        end
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(negedge clk);
        cycle();
        cycle();
        reset = 0;
        // Reset state with quiet inputs: default outputs
        cycle();

        // Load-use
        e_wa = 8; e_tnew = 2; d_rs = 8; d_tuse_rs = 1;
        #1;
        check("loaduse_stall", 32'(stall), 32'd1);
        check("loaduse_bubble", 32'({pc_en, de_bubble}), 32'b01);
        cycle();

        // $0 never hazards
        idle_inputs();
        d_rs = 0; e_wa = 0; e_tnew = 2; d_tuse_rs = 0;
        #1;
        check("zero_reg_stall", 32'(stall), 32'd0);
        cycle();

        // Div: 10 busy cycles, d_is_md stalled for start + 10
        idle_inputs();
        e_md_start = 1; e_md_div = 1; d_is_md = 1;
        cycle();
        e_md_start = 0; e_md_div = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("div_busy", 32'(md_busy), 32'd1);
            check("div_md_stall", 32'(stall), 32'd1);
            cycle();
        end
        #1;
        check("div_done_busy", 32'(md_busy), 32'd0);
        check("div_done_stall", 32'(stall), 32'd0);
        cycle();

        // Exception suppresses a start and overrides a data stall
        idle_inputs();
        exc_req = 1; e_md_start = 1; e_wa = 8; e_tnew = 2; d_rs = 8; d_tuse_rs = 1;
        #1;
        check("exc_start_ok", 32'(md_start_ok), 32'd0);
        check("exc_pc_sel", 32'(pc_sel), 32'd1);
        check("exc_pc_en", 32'(pc_en), 32'd1);
        cycle();
        idle_inputs();
        #1;
        check("exc_no_busy", 32'(md_busy), 32'd0);
        cycle();

        // exc wins over eret; eret alone selects EPC
        exc_req = 1; eret_req = 1;
        #1;
        check("exc_eret_sel", 32'(pc_sel), 32'd1);
        cycle();
        exc_req = 0;
        #1;
        check("eret_sel", 32'(pc_sel), 32'd2);
        cycle();

        // Exception mid-BUSY does not abort the mult
        idle_inputs();
        e_md_start = 1;
        cycle();
        e_md_start = 0;
        cycle();
        exc_req = 1;
        cycle();
        exc_req = 0;
        #1;
        check("exc_mid_busy", 32'(md_busy), 32'd1);
        cycle();
        cycle();
        cycle();
        #1;
        check("mult_len_done", 32'(md_busy), 32'd0);
        cycle();

        // Reset during 3rd BUSY cycle of a mult
        d_is_md = 1; e_md_start = 1;
        cycle();
        e_md_start = 0;
        cycle();
        cycle();
        reset = 1;
        #1;
        check("mult_3rd_busy", 32'(md_busy), 32'd1);
        cycle();
        reset = 0; d_is_md = 0;
        #1;
        check("rst_mid_busy", 32'(md_busy), 32'd0);
`ifdef PIPE_CTRL_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        cycle();

        // Randomized traffic with a small register pool to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            d_rs       = 5'($urandom_range(0, 3));
            d_rt       = 5'($urandom_range(0, 3));
            e_wa       = 5'($urandom_range(0, 3));
            m_wa       = 5'($urandom_range(0, 3));
            d_tuse_rs  = 2'($urandom_range(0, 3));
            d_tuse_rt  = 2'($urandom_range(0, 3));
            e_tnew     = 2'($urandom_range(0, 3));
            m_tnew     = 2'($urandom_range(0, 3));
            d_is_md    = ($urandom_range(0, 9) < 3);
            e_md_start = ($urandom_range(0, 9) == 0);
            e_md_div   = 1'($urandom_range(0, 1));
            exc_req    = ($urandom_range(0, 19) == 0);
            eret_req   = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
